// File: rtl/key_switch_conditioner.sv
// Purpose: conditions raw board buttons and slide switches into clean synchronous levels and press pulses.
// Latency: KEY_LVL/KEY_PRESS DEBOUNCE_CYCLES+3 edges; SW_OUT 2 edges (DEBOUNCE_CYCLES+3 with SW_DEBOUNCE_EN).
// Backpressure: none; free-running level path, outputs update every cycle. Optional macro: SW_DEBOUNCE_EN.
module key_switch_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_WIDTH       = 20
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [1:0] KEY,
  input  logic [7:0] SW,
  output logic [1:0] KEY_LVL,
  output logic [1:0] KEY_PRESS,
  output logic [7:0] SW_OUT
);

  // Terminal count: a change is accepted when the wait counter reaches this value
  // while the input still disagrees with the accepted level.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_t;

  logic [1:0] key_s1, key_s2;
  logic [7:0] sw_s1, sw_s2;
  logic [1:0] kp;

  // Two-flop synchronizers; keys restart released so a held key is re-detected after reset.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      key_s1 <= 2'b11;
      key_s2 <= 2'b11;
      sw_s1  <= 8'h00;
      sw_s2  <= 8'h00;
    end else begin
      key_s1 <= KEY;
      key_s2 <= key_s1;
      sw_s1  <= SW;
      sw_s2  <= sw_s1;
    end
  end

  // Buttons are active-low on the board; the debouncers work in pressed=1 terms.
  assign kp = ~key_s2;

  for (genvar i = 0; i < 2; i++) begin : g_key
    db_state_t            state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 lvl_q, lvl_d;
    logic                 press_q, press_d;

    // Key debounce state, counter and registered outputs.
    always_ff @(posedge CLK) begin
      if (!RESET_N) begin
        state_q <= IDLE;
        cnt_q   <= CNT_ZERO;
        lvl_q   <= 1'b0;
        press_q <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        lvl_q   <= lvl_d;
        press_q <= press_d;
      end
    end

    // Next-state: any disagreeing sample restarts the wait; only a completed press wait pulses.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lvl_d   = lvl_q;
      press_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (kp[i]) begin
            state_d = PRESS_WAIT;
            cnt_d   = CNT_ZERO;
          end
        end
        PRESS_WAIT: begin
          if (!kp[i]) begin
            state_d = IDLE;
            cnt_d   = CNT_ZERO;
          end else if (cnt_q == CNT_LAST) begin
            state_d = PRESSED;
            cnt_d   = CNT_ZERO;
            lvl_d   = 1'b1;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!kp[i]) begin
            state_d = RELEASE_WAIT;
            cnt_d   = CNT_ZERO;
          end
        end
        RELEASE_WAIT: begin
          if (kp[i]) begin
            state_d = PRESSED;
            cnt_d   = CNT_ZERO;
          end else if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            cnt_d   = CNT_ZERO;
            lvl_d   = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
          lvl_d   = 1'b0;
        end
      endcase
    end

    assign KEY_LVL[i]   = lvl_q;
    assign KEY_PRESS[i] = press_q;
  end

`ifdef SW_DEBOUNCE_EN
  for (genvar j = 0; j < 8; j++) begin : g_sw
    db_state_t            state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 lvl_q, lvl_d;

    // Switch debounce state, counter and registered level.
    always_ff @(posedge CLK) begin
      if (!RESET_N) begin
        state_q <= IDLE;
        cnt_q   <= CNT_ZERO;
        lvl_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        lvl_q   <= lvl_d;
      end
    end

    // Same filter as the keys, level only: a switch flip has no pulse meaning.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lvl_d   = lvl_q;
      case (state_q)
        IDLE: begin
          if (sw_s2[j]) begin
            state_d = PRESS_WAIT;
            cnt_d   = CNT_ZERO;
          end
        end
        PRESS_WAIT: begin
          if (!sw_s2[j]) begin
            state_d = IDLE;
            cnt_d   = CNT_ZERO;
          end else if (cnt_q == CNT_LAST) begin
            state_d = PRESSED;
            cnt_d   = CNT_ZERO;
            lvl_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!sw_s2[j]) begin
            state_d = RELEASE_WAIT;
            cnt_d   = CNT_ZERO;
          end
        end
        RELEASE_WAIT: begin
          if (sw_s2[j]) begin
            state_d = PRESSED;
            cnt_d   = CNT_ZERO;
          end else if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            cnt_d   = CNT_ZERO;
            lvl_d   = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
          lvl_d   = 1'b0;
        end
      endcase
    end

    assign SW_OUT[j] = lvl_q;
  end
`else
  // Switches only need metastability protection; the second stage is already a flop.
  assign SW_OUT = sw_s2;
`endif

endmodule

// File: tb/tb_key_switch_conditioner.sv
module tb_key_switch_conditioner;

  localparam int N = 4;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic [1:0] KEY;
  logic [7:0] SW;
  logic [1:0] KEY_LVL;
  logic [1:0] KEY_PRESS;
  logic [7:0] SW_OUT;

  always #5 CLK = ~CLK;

  key_switch_conditioner #(.DEBOUNCE_CYCLES(N), .CNT_WIDTH(3)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .KEY(KEY), .SW(SW),
    .KEY_LVL(KEY_LVL), .KEY_PRESS(KEY_PRESS), .SW_OUT(SW_OUT)
  );

  typedef struct packed {
    logic [1:0] lvl;
    logic [1:0] press;
    logic [7:0] sw;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   pc0    = 0;
  int   pc1    = 0;

  // Reference model: raw inputs reach the filter two edges late; a level
  // changes once the filtered input has shown the new value for N+1
  // consecutive samples.
  logic [1:0] key_pipe[$];
  logic [7:0] sw_pipe[$];
  int         run_k[2];
  logic [1:0] last_k;
  logic [1:0] m_lvl;
  int         run_s[8];
  logic [7:0] last_s;
  logic [7:0] m_sw;

  task automatic model_reset();
    key_pipe = {2'b11, 2'b11};
    sw_pipe  = {8'h00, 8'h00};
    for (int i = 0; i < 2; i++) run_k[i] = 0;
    for (int i = 0; i < 8; i++) run_s[i] = 0;
    last_k = '0;
    last_s = '0;
    m_lvl  = '0;
    m_sw   = '0;
  endtask

  task automatic model_edge(input logic rst_n, input logic [1:0] key, input logic [7:0] sw, output exp_t e);
    logic [1:0] kraw;
    logic [1:0] kp;
    logic [7:0] sdel;
    logic [1:0] press;
    press = '0;
    if (!rst_n) begin
      model_reset();
      e.lvl = '0; e.press = '0; e.sw = '0;
    end else begin
      kraw = key_pipe.pop_front();
      key_pipe.push_back(key);
      kp = ~kraw;
      sdel = sw_pipe.pop_front();
      sw_pipe.push_back(sw);
      for (int i = 0; i < 2; i++) begin
        if (run_k[i] > 0 && last_k[i] == kp[i]) run_k[i]++;
        else begin run_k[i] = 1; last_k[i] = kp[i]; end
        if (run_k[i] >= N + 1 && kp[i] != m_lvl[i]) begin
          m_lvl[i] = kp[i];
          press[i] = kp[i];
        end
      end
`ifdef SW_DEBOUNCE_EN
      for (int i = 0; i < 8; i++) begin
        if (run_s[i] > 0 && last_s[i] == sdel[i]) run_s[i]++;
        else begin run_s[i] = 1; last_s[i] = sdel[i]; end
        if (run_s[i] >= N + 1) m_sw[i] = sdel[i];
      end
`else
      m_sw = sw_pipe[0];
`endif
      e.lvl = m_lvl; e.press = press; e.sw = m_sw;
    end
  endtask

  // Drive one cycle of stimulus and queue the response expected after the next edge.
  task automatic step(input logic rst_n, input logic [1:0] key, input logic [7:0] sw);
    exp_t e;
    RESET_N = rst_n;
    KEY     = key;
    SW      = sw;
    model_edge(rst_n, key, sw, e);
    expq.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  task automatic hold(input int n, input logic rst_n, input logic [1:0] key, input logic [7:0] sw);
    for (int i = 0; i < n; i++) step(rst_n, key, sw);
  endtask

  task automatic clr_pulses();
    @(negedge CLK);
    #1;
    pc0 = 0;
    pc1 = 0;
  endtask

  task automatic chk_pulses(input string name, input int want0, input int want1);
    @(negedge CLK);
    #1;
    checks++;
    if (pc0 != want0 || pc1 != want1) begin
      errors++;
      $display("FAIL %s pulses got key0=%0d key1=%0d want key0=%0d key1=%0d", name, pc0, pc1, want0, want1);
    end
  endtask

  // Monitor: every edge presents a new output word; compare it against the queued expectation.
  always @(negedge CLK) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      cyc++;
      pc0 += int'(KEY_PRESS[0]);
      pc1 += int'(KEY_PRESS[1]);
      checks++;
      if (KEY_LVL !== e.lvl) begin
        errors++;
        $display("FAIL key_lvl cyc=%0d got %b want %b", cyc, KEY_LVL, e.lvl);
      end
      checks++;
      if (KEY_PRESS !== e.press) begin
        errors++;
        $display("FAIL key_press cyc=%0d got %b want %b", cyc, KEY_PRESS, e.press);
      end
      checks++;
      if (SW_OUT !== e.sw) begin
        errors++;
        $display("FAIL sw_out cyc=%0d got %h want %h", cyc, SW_OUT, e.sw);
      end
    end
  end

  initial begin
    logic [1:0] k;
    logic [7:0] s;
    logic       r;
    model_reset();

    // Reset with keys pressed and switches high: everything must read zero.
    hold(2, 1'b0, 2'b00, 8'hFF);
    hold(3, 1'b1, 2'b11, 8'h00);

    // Clean press on key 0 plus a switch step.
    clr_pulses();
    hold(10, 1'b1, 2'b10, 8'b0110_1010);
    chk_pulses("clean_press", 1, 0);

    // Release, then bounce: low 3, high 1, low held.
    hold(10, 1'b1, 2'b11, 8'b0110_1010);
    clr_pulses();
    hold(3, 1'b1, 2'b10, 8'h00);
    hold(1, 1'b1, 2'b11, 8'h00);
    hold(10, 1'b1, 2'b10, 8'h00);
    chk_pulses("bounce", 1, 0);

    // Release glitch while pressed: high 2, low 1, high held; no pulse.
    clr_pulses();
    hold(2, 1'b1, 2'b11, 8'h00);
    hold(1, 1'b1, 2'b10, 8'h00);
    hold(10, 1'b1, 2'b11, 8'h00);
    chk_pulses("release_glitch", 0, 0);

    // Reset in the middle of a key 1 press wait.
    hold(5, 1'b1, 2'b01, 8'h00);
    clr_pulses();
    hold(1, 1'b0, 2'b01, 8'h00);
    hold(10, 1'b1, 2'b01, 8'h00);
    chk_pulses("reset_mid_wait", 0, 1);

    // Simultaneous presses on both keys.
    hold(10, 1'b1, 2'b11, 8'h00);
    clr_pulses();
    hold(10, 1'b1, 2'b00, 8'h3C);
    chk_pulses("both_keys", 1, 1);

    // Randomized phase: slow key/switch changes with bounce, occasional reset.
    k = 2'b11;
    s = 8'h00;
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < 2; b++)
        if ($urandom_range(0, 9) == 0) k[b] = ~k[b];
      if ($urandom_range(0, 14) == 0) s = 8'($urandom);
      else if ($urandom_range(0, 9) == 0) s[$urandom_range(0, 7)] ^= 1'b1;
      r = ($urandom_range(0, 199) != 0);
      step(r, k, s);
    end

    @(negedge CLK);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
